// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - iterative AES-128/192/256 key schedule with round-key read port
//
// Computes one 32-bit schedule word per clock into an internal word array.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, key_len, key   expansion request, key length select, cipher key (word0 at MSBs)
//   busy, done, key_valid expansion running, completion pulse, schedule-stable level
//   err                   pulse when a start is rejected for an illegal key length
//   nr                    round count of the captured mode (0 after reset)
//   rd_idx, rd_key        combinational round-key read port (zero when rd_idx > nr)
module aes_key_expand_seq #(
    parameter int MAX_NK = 8,
    parameter int KEY_W  = 32 * MAX_NK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             done,
    output logic             key_valid,
    output logic             err,
    output logic [3:0]       nr,
    input  logic [3:0]       rd_idx,
    output logic [127:0]     rd_key
);

    localparam int NW = 4 * (MAX_NK + 7);
    localparam int IW = $clog2(NW);
    localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127, inv;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        inv  = gf_mul(x127, x127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sub_byte(v[31:24]), sub_byte(v[23:16]), sub_byte(v[15:8]), sub_byte(v[7:0])};
    endfunction

    state_t         state_q, state_d;
    logic [IW-1:0]  i_q, i_d;
    logic [2:0]     j_q, j_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [3:0]     nk_q, nk_d;
    logic [3:0]     nr_q, nr_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [31:0]    w_q [0:NW-1];

    logic [3:0]     req_nk;
    logic           legal;
    logic           load_en;
    logic           wr_en;
    logic           last;
    logic [31:0]    prev_w;
    logic [31:0]    temp;
    logic [31:0]    w_new;
    logic [IW-1:0]  rd_base;

    always_comb begin
        case (key_len)
            2'b00:   req_nk = 4'd4;
            2'b01:   req_nk = 4'd6;
            2'b10:   req_nk = 4'd8;
            default: req_nk = 4'd0;
        endcase
    end

    assign legal  = (key_len != 2'b11) && (req_nk <= MAX_NK_L);
    assign last   = (i_q == IW'({nr_q, 2'b00}) + IW'(3));
    assign prev_w = w_q[i_q - IW'(1)];

    always_comb begin
        temp = prev_w;
        if (j_q == 3'd0) begin
            temp = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
        end else if (nk_q == 4'd8 && j_q == 3'd4) begin
            temp = sub_word(prev_w);
        end
        w_new = w_q[i_q - IW'(nk_q)] ^ temp;
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        nk_d    = nk_q;
        nr_d    = nr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_en = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (!legal) begin
                        err_d = 1'b1;
                    end else begin
                        load_en = 1'b1;
                        nk_d    = req_nk;
                        nr_d    = req_nk + 4'd6;
                        i_d     = IW'(req_nk);
                        j_d     = 3'd0;
                        rcon_d  = 8'h01;
                        state_d = S_EXPAND;
                    end
                end
            end
            S_EXPAND: begin
                wr_en = 1'b1;
                i_d   = i_q + IW'(1);
                // Phase counter wraps at Nk without a modulo operator.
                j_d   = (({1'b0, j_q} + 4'd1) == nk_q) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) rcon_d = xtime(rcon_q);
                if (last) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= 3'd0;
            rcon_q  <= 8'h00;
            nk_q    <= 4'd0;
            nr_q    <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            nk_q    <= nk_d;
            nr_q    <= nr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) w_q[k] <= 32'h0;
        end else if (load_en) begin
            for (int k = 0; k < MAX_NK; k++) begin
                if (4'(k) < req_nk) w_q[k] <= key[KEY_W-1-32*k -: 32];
            end
        end else if (wr_en) begin
            w_q[i_q] <= w_new;
        end
    end

    assign rd_base = IW'({rd_idx, 2'b00});
    assign rd_key  = (rd_idx > nr_q) ? 128'h0
                   : {w_q[rd_base], w_q[rd_base + IW'(1)], w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]};

    assign busy      = (state_q == S_EXPAND);
    assign key_valid = (state_q == S_DONE);
    assign done      = done_q;
    assign err       = err_q;
    assign nr        = nr_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - directed self-checking bench for aes_key_expand_seq
module tb_aes_key_expand_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic         err;
    logic [3:0]   nr;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int total = 0;
    int bad   = 0;
    int cnt;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_expand_seq #(.MAX_NK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_len   (key_len),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .err       (err),
        .nr        (nr),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
        key_len = kl;
        key     = k;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        rd_idx = idx;
        #1;
        chk(tag, rd_key, exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        key_len = 2'b00;
        key     = '0;
        rd_idx  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_kv", 128'(key_valid), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_nr", 128'(nr), 128'd0);
        rd("rst_rd0", 4'd0, 128'h0);

        // AES-128
        do_start(2'b00, K128);
        chk("a128_busy", 128'(busy), 128'd1);
        chk("a128_kv_low", 128'(key_valid), 128'd0);
        chk("a128_nr", 128'(nr), 128'd10);
        wait_done(cnt);
        chk("a128_lat", 128'(cnt), 128'd40);
        chk("a128_kv", 128'(key_valid), 128'd1);
        chk("a128_busy_end", 128'(busy), 128'd0);
        rd("a128_r0", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd("a128_r1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd("a128_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd("a128_r11", 4'd11, 128'h0);
        step();
        chk("a128_done_pulse", 128'(done), 128'd0);

        // Illegal key length
        do_start(2'b11, K256);
        chk("ill_err", 128'(err), 128'd1);
        chk("ill_busy", 128'(busy), 128'd0);
        chk("ill_kv", 128'(key_valid), 128'd1);
        chk("ill_nr", 128'(nr), 128'd10);
        step();
        chk("ill_err_pulse", 128'(err), 128'd0);
        rd("ill_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192 with an ignored mid-run start
        do_start(2'b01, K192);
        repeat (10) step();
        do_start(2'b00, K128);
        chk("a192_ign_busy", 128'(busy), 128'd1);
        chk("a192_ign_err", 128'(err), 128'd0);
        wait_done(cnt);
        chk("a192_lat", 128'(cnt + 11), 128'd46);
        chk("a192_nr", 128'(nr), 128'd12);
        rd("a192_r0", 4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
        rd("a192_r12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);
        rd("a192_r13", 4'd13, 128'h0);

        // Reset mid-run of AES-256
        do_start(2'b10, K256);
        repeat (19) step();
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 128'(busy), 128'd0);
        chk("mrst_kv", 128'(key_valid), 128'd0);
        chk("mrst_nr", 128'(nr), 128'd0);
        chk("mrst_done", 128'(done), 128'd0);
        rd("mrst_rd0", 4'd0, 128'h0);
        step();
        rst_n = 1'b1;
        step();

        do_start(2'b00, K128);
        wait_done(cnt);
        chk("post_rst_lat", 128'(cnt), 128'd40);
        rd("post_rst_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Back-to-back: restart in the done cycle
        do_start(2'b00, K128);
        chk("b2b1_kv", 128'(key_valid), 128'd0);
        chk("b2b1_busy", 128'(busy), 128'd1);
        wait_done(cnt);
        chk("b2b1_lat", 128'(cnt), 128'd40);
        rd("b2b1_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_start(2'b10, K256);
        chk("b2b2_kv", 128'(key_valid), 128'd0);
        chk("b2b2_busy", 128'(busy), 128'd1);
        wait_done(cnt);
        chk("a256_lat", 128'(cnt), 128'd52);
        chk("a256_nr", 128'(nr), 128'd14);
        rd("a256_r0", 4'd0, 128'h603deb1015ca71be2b73aef0857d7781);
        rd("a256_r1", 4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
        rd_idx = 4'd2;
        #1;
        chk("a256_w8", 128'(rd_key[127:96]), 128'h9ba35411);
        rd("a256_r14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        rd("a256_r15", 4'd15, 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
Iterative AES key-schedule engine for AES-128, AES-192 and AES-256. The key length is selected at run time, up to a compile-time maximum. It computes one 32-bit schedule word per clock and stores the schedule in an internal register array. The cipher datapath reads round keys from that array through a combinational read port indexed by round.

Parameters:
MAX_NK, 8, largest supported key length in 32-bit words (legal: 4, 6, 8); schedule storage is 4*(MAX_NK+7) words
KEY_W, 32*MAX_NK, width of the key input (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request expansion; sampled only when not busy
key_len  in  2  00=AES-128 (Nk=4), 01=AES-192 (Nk=6), 10=AES-256 (Nk=8), 11=illegal
key  in  KEY_W  cipher key, word0 at key[KEY_W-1 -: 32]; an Nk-word key occupies the top 32*Nk bits, lower bits ignored
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when the last word has been written
key_valid  out  1  schedule complete and stable; level
err  out  1  one-cycle pulse when start is rejected for illegal key_len
nr  out  4  round count of the captured mode (10/12/14); 0 after reset
rd_idx  in  4  round-key index 0..nr
rd_key  out  128  words 4*rd_idx..4*rd_idx+3, with word 4*rd_idx in bits [127:96]

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low asynchronously clears the state to IDLE and clears every storage word, busy, done, key_valid, err and nr to 0.
  - Reset mid-expansion aborts the run; there is no resume.
- States: IDLE, EXPAND, DONE.
- Start acceptance:
  - start is sampled at an edge while in IDLE or DONE.
  - If key_len selects Nk > MAX_NK, or key_len=11: err pulses for the next cycle, no other output or state changes, and key_valid keeps its value.
  - Otherwise, at that edge:
    - Nk words are written from key into w[0..Nk-1].
    - nr is set to Nk+6.
    - Word index i is set to Nk and phase counter j is set to 0.
    - rcon is set to 0x01.
    - key_valid goes to 0, busy goes to 1, and the state goes to EXPAND.
  - start while busy is ignored (no err).
- EXPAND, one word per edge:
  - temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, where RotWord is a left byte-rotate; then rcon = xtime(rcon), i.e. shift left 1, XOR 0x1b if bit7 was set.
  - Else if Nk==8 and j==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - i increments; j increments and wraps to 0 at Nk (no divider or modulo operator).
  - SubWord applies the standard AES S-box to each byte (4 S-box instances).
- Completion:
  - When i == 4*(nr+1)-1 is written: busy=0, key_valid=1, state goes to DONE, and done is high for exactly the following cycle.
  - Latency from the accepting edge to the done-high cycle is 4*(nr+1)-Nk edges: 40 (128), 46 (192), 52 (256).
- Read port:
  - Purely combinational from the storage.
  - rd_idx > nr returns 128'h0.
  - While busy, the port returns the current array contents, which are partial and not guaranteed; consumers gate on key_valid.
- Storage words beyond 4*(nr+1) keep their stale values, but they are never visible through rd_key.
- Restart from DONE is permitted; key_valid drops on the accepting edge.

Test Plan:
- AES-128 (FIPS-197 A.1): key_len=00, key top bits 2b7e151628aed2a6abf7158809cf4f3c.
  - done appears 40 cycles after start.
  - rd_idx=1 gives a0fafe1788542cb123a339392a6c7605.
  - rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_idx=11 gives 0.
- AES-192 (A.2): key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - done appears after 46 cycles and nr=12.
  - rd_idx=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256 (A.3): key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - done appears after 52 cycles.
  - w[8]=9ba35411, checked via rd_idx=2 bits [127:96].
  - rd_idx=14 gives fe4890d1e6188d0b046df344706c631e.
- Illegal and ignored starts:
  - key_len=11 gives a one-cycle err pulse, busy stays 0, and key_valid and nr are unchanged.
  - start pulsed mid-run is ignored, and the run still completes with the correct values.
- Reset mid-run: drop rst_n at cycle 20 of an AES-256 run.
  - Outputs and the array clear immediately.
  - A subsequent AES-128 run produces the A.1 round-10 key.
- Back-to-back: accept an AES-128 start in the done cycle, then an AES-256 start after the next done.
  - key_valid deasserts on each accepting edge.
  - Final rd_key values match the A.3 vectors.
